// File: rtl/mul_acc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muladd_pkg
// Brief    : Shared types, default widths and saturation helper for the MulAdd
//            accumulator datapath.
// Revision : 1.0
// ============================================================================
package muladd_pkg;

  localparam int c_width_data = 8;
  localparam int c_width_acc  = 24;
  localparam int c_width_cnt  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two's-complement limit of a width-bit signed value, sign-extended to 64 bits.
  function automatic logic [63:0] sat_limit(input int unsigned width, input logic neg);
    logic [63:0] v_min;
    v_min = {64{1'b1}} << (width - 1);
    return neg ? v_min : ~v_min;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_acc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_acc_unit_if
// Brief    : Job control, operand stream and result stream of mul_acc_unit.
// Revision : 1.0
// ============================================================================
interface mul_acc_unit_if
  import muladd_pkg::*;
#(
  parameter int WIDTH_DATA = c_width_data,
  parameter int WIDTH_ACC  = c_width_acc,
  parameter int WIDTH_CNT  = c_width_cnt
);

  logic                         start_i;
  logic [WIDTH_CNT-1:0]         cfg_len_i;
  logic signed [WIDTH_DATA-1:0] a_i;
  logic signed [WIDTH_DATA-1:0] b_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [WIDTH_ACC-1:0]         acc_o;
  logic                         ovf_o;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic                         busy_o;

  modport slave (
    input  start_i, cfg_len_i, a_i, b_i, in_valid_i, out_ready_i,
    output in_ready_o, acc_o, ovf_o, out_valid_o, busy_o
  );

  modport master (
    output start_i, cfg_len_i, a_i, b_i, in_valid_i, out_ready_i,
    input  in_ready_o, acc_o, ovf_o, out_valid_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/mul_acc_unit_mac_product_reg.sv
`default_nettype none
// ============================================================================
// Module   : mac_product_reg
// Brief    : Registered signed multiplier stage with a product-valid flag.
// Revision : 1.0
// ============================================================================
module mac_product_reg #(
  parameter int WIDTH_DATA = 8
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  input  wire logic                           i_load,
  input  wire logic signed [WIDTH_DATA-1:0]   i_a,
  input  wire logic signed [WIDTH_DATA-1:0]   i_b,
  output logic signed      [2*WIDTH_DATA-1:0] o_prod_q,
  output logic                                o_prod_v
);

  logic signed [2*WIDTH_DATA-1:0] w_prod;
  logic signed [2*WIDTH_DATA-1:0] r_prod_q;
  logic                           r_prod_v;

  assign w_prod = (2*WIDTH_DATA)'(i_a) * (2*WIDTH_DATA)'(i_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod_q <= '0;
      r_prod_v <= 1'b0;
    end else begin
      r_prod_v <= i_load;
      if (i_load) begin
        r_prod_q <= w_prod;
      end
    end
  end

  assign o_prod_q = r_prod_q;
  assign o_prod_v = r_prod_v;

endmodule
`default_nettype wire

// File: rtl/mul_acc_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_acc_unit
// Brief    : Signed multiply-accumulate job engine. Define MULADD_ACC_SAT_EN to
//            clamp the accumulator on overflow instead of wrapping.
// Revision : 1.0
// ============================================================================
module mul_acc_unit
  import muladd_pkg::*;
#(
  parameter int WIDTH_DATA = c_width_data,
  parameter int WIDTH_ACC  = c_width_acc,
  parameter int WIDTH_CNT  = c_width_cnt
) (
  input wire logic       clk,
  input wire logic       rst,
  mul_acc_unit_if.slave  bus
);

  state_t                         r_state;
  state_t                         w_state_next;
  logic [WIDTH_CNT-1:0]           r_remaining;
  logic signed [WIDTH_ACC-1:0]    r_acc;
  logic                           r_ovf;
  logic signed [2*WIDTH_DATA-1:0] w_prod_q;
  logic                           w_prod_v;
  logic signed [WIDTH_ACC-1:0]    w_prod_ext;
  logic signed [WIDTH_ACC-1:0]    w_sum;
  logic signed [WIDTH_ACC-1:0]    w_acc_next;
  logic                           w_add_ovf;
  logic                           w_accept;
  logic                           w_start;
  logic                           w_last;
  logic                           w_in_ready;
  logic                           w_out_valid;
  logic                           w_busy;

  assign w_accept = bus.in_valid_i && w_in_ready;
  assign w_start  = (r_state == IDLE) && bus.start_i;
  assign w_last   = (r_remaining == WIDTH_CNT'(1));

  mac_product_reg #(
    .WIDTH_DATA (WIDTH_DATA)
  ) u_product (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_a      (bus.a_i),
    .i_b      (bus.b_i),
    .o_prod_q (w_prod_q),
    .o_prod_v (w_prod_v)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_state_next = (bus.cfg_len_i == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (w_accept && w_last) begin
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        w_state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE:    w_busy      = 1'b0;
      ACC:     w_in_ready  = 1'b1;
      DONE:    w_out_valid = 1'b1;
      default: w_busy      = 1'b1;
    endcase
  end

  // Overflow happens only when both addends share a sign the sum does not.
  assign w_prod_ext = WIDTH_ACC'(w_prod_q);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[WIDTH_ACC-1] == w_prod_ext[WIDTH_ACC-1]) &&
                      (w_sum[WIDTH_ACC-1] != r_acc[WIDTH_ACC-1]);

`ifdef MULADD_ACC_SAT_EN
  assign w_acc_next = !w_add_ovf          ? w_sum :
                      r_acc[WIDTH_ACC-1]  ? WIDTH_ACC'(sat_limit(WIDTH_ACC, 1'b1)) :
                                            WIDTH_ACC'(sat_limit(WIDTH_ACC, 1'b0));
`else
  assign w_acc_next = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_remaining <= '0;
    end else if (w_start) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_remaining <= bus.cfg_len_i;
    end else begin
      if (w_accept) begin
        r_remaining <= r_remaining - WIDTH_CNT'(1);
      end
      if (w_prod_v) begin
        r_acc <= w_acc_next;
        if (w_add_ovf) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.busy_o      = w_busy;
  assign bus.acc_o       = r_acc;
  assign bus.ovf_o       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mul_acc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_acc_unit
// Brief    : Self-checking bench for mul_acc_unit (24-bit and 16-bit builds).
// Revision : 1.0
// ============================================================================
module tb_mul_acc_unit;

  localparam int WD   = 8;
  localparam int WA   = 24;
  localparam int WA16 = 16;
  localparam int WC   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_acc_unit_if #(.WIDTH_DATA(WD), .WIDTH_ACC(WA),   .WIDTH_CNT(WC)) bus ();
  mul_acc_unit_if #(.WIDTH_DATA(WD), .WIDTH_ACC(WA16), .WIDTH_CNT(WC)) bus16 ();

  mul_acc_unit #(.WIDTH_DATA(WD), .WIDTH_ACC(WA),   .WIDTH_CNT(WC)) dut   (.clk(clk), .rst(rst), .bus(bus));
  mul_acc_unit #(.WIDTH_DATA(WD), .WIDTH_ACC(WA16), .WIDTH_CNT(WC)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int checks   = 0;
  int failures = 0;
  int qa[$];
  int qb[$];

  // Reference: running signed sum of products, wrapped or clamped at each step.
  function automatic void model(input int w, output logic [63:0] acc_v, output bit ovf);
    longint acc, one, span, hi, lo;
    one = 1; span = one <<< w; hi = span / 2 - 1; lo = -(span / 2);
    acc = 0; ovf = 1'b0;
    foreach (qa[i]) begin
      acc += longint'(qa[i]) * longint'(qb[i]);
      if (acc > hi || acc < lo) begin
        ovf = 1'b1;
`ifdef MULADD_ACC_SAT_EN
        acc = (acc > hi) ? hi : lo;
`else
        acc = (acc > hi) ? acc - span : acc + span;
`endif
      end
    end
    acc_v = acc;
  endfunction

  task automatic drive_job(input int len, input int bubble_pct, input logic [31:0] vmask,
                           input bit use_mask, input int hold, input bit poke,
                           output logic [WA-1:0] acc, output logic ovf, output int lat,
                           output bit stable, output bit saw_ready, output logic busy_after,
                           output bit timeout);
    int idx, cyc;
    bit v;
    timeout = 0; stable = 1; saw_ready = 0; idx = 0; cyc = 0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.cfg_len_i = WC'(len);
    @(negedge clk);
    bus.start_i = poke;
    if (poke) bus.cfg_len_i = WC'($urandom_range(1, 31));
    while (idx < len && cyc < 300) begin
      v = use_mask ? vmask[cyc % 32] : ($urandom_range(0, 99) >= bubble_pct);
      bus.in_valid_i = v;
      bus.a_i = WD'(qa[idx]);
      bus.b_i = WD'(qb[idx]);
      if (bus.in_ready_o) saw_ready = 1;
      if (v && bus.in_ready_o) idx++;
      @(negedge clk);
      cyc++;
    end
    if (idx < len) timeout = 1;
    bus.in_valid_i = 1'b0;
    bus.a_i = WD'($urandom);
    bus.b_i = WD'($urandom);
    lat = 1;
    while (!bus.out_valid_o && lat < 50) begin
      if (bus.in_ready_o) saw_ready = 1;
      @(negedge clk);
      lat++;
    end
    if (bus.out_valid_o !== 1'b1) timeout = 1;
    acc = bus.acc_o;
    ovf = bus.ovf_o;
    for (int i = 0; i < hold; i++) begin
      bus.out_ready_i = 1'b0;
      @(negedge clk);
      if (bus.acc_o !== acc || bus.ovf_o !== ovf || bus.out_valid_o !== 1'b1) stable = 0;
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.start_i     = 1'b0;
    busy_after      = bus.busy_o;
  endtask

  task automatic run16(input int n, output logic [WA16-1:0] acc, output logic ovf, output bit timeout);
    int idx, cyc;
    timeout = 0; idx = 0; cyc = 0;
    @(negedge clk);
    bus16.start_i = 1'b1; bus16.cfg_len_i = WC'(n);
    @(negedge clk);
    bus16.start_i = 1'b0;
    while (idx < n && cyc < 100) begin
      bus16.in_valid_i = 1'b1;
      bus16.a_i = WD'(qa[idx]);
      bus16.b_i = WD'(qb[idx]);
      if (bus16.in_ready_o) idx++;
      @(negedge clk);
      cyc++;
    end
    bus16.in_valid_i = 1'b0;
    cyc = 0;
    while (!bus16.out_valid_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (bus16.out_valid_o !== 1'b1 || idx < n) timeout = 1;
    acc = bus16.acc_o;
    ovf = bus16.ovf_o;
    bus16.out_ready_i = 1'b1;
    @(negedge clk);
    bus16.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i = 0; bus.cfg_len_i = '0; bus.a_i = '0; bus.b_i = '0; bus.in_valid_i = 0; bus.out_ready_i = 0;
    bus16.start_i = 0; bus16.cfg_len_i = '0; bus16.a_i = '0; bus16.b_i = '0; bus16.in_valid_i = 0; bus16.out_ready_i = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready_o); end
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.acc_o !== '0) begin failures++; $display("FAIL reset_acc got=%0h exp=0", bus.acc_o); end
    checks++; if (bus.ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf_o); end
  endtask

  task automatic test_basic();
    logic [WA-1:0] acc; logic ovf; int lat; bit st, sr, to; logic ba;
    qa = {2, -4, 7}; qb = {3, 5, 7};
    drive_job(3, 0, 32'h0, 0, 0, 0, acc, ovf, lat, st, sr, ba, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (acc !== WA'(35)) begin failures++; $display("FAIL basic_acc got=%0d exp=35", acc); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_bubbles_backpressure();
    logic [WA-1:0] acc; logic ovf; int lat; bit st, sr, to; logic ba;
    qa = {10, -1}; qb = {10, 1};
    drive_job(2, 0, 32'b1001, 1, 5, 0, acc, ovf, lat, st, sr, ba, to);
    checks++; if (to) begin failures++; $display("FAIL bubbles_timeout got=1 exp=0"); end
    checks++; if (acc !== WA'(99)) begin failures++; $display("FAIL bubbles_acc got=%0d exp=99", acc); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL bubbles_hold_stable got=%b exp=1", st); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL bubbles_latency got=%0d exp=2", lat); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL bubbles_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_zero_len();
    logic [WA-1:0] acc; logic ovf; int lat; bit st, sr, to; logic ba;
    qa = {}; qb = {};
    drive_job(0, 0, 32'h0, 0, 2, 0, acc, ovf, lat, st, sr, ba, to);
    checks++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (acc !== '0) begin failures++; $display("FAIL zero_acc got=%0d exp=0", acc); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL zero_ovf got=%b exp=0", ovf); end
    checks++; if (sr !== 1'b0) begin failures++; $display("FAIL zero_in_ready_seen got=%b exp=0", sr); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_overflow();
    logic [WA16-1:0] acc; logic ovf; bit to; logic [63:0] m; bit movf;
    qa = {127, 127, 127}; qb = {127, 127, 127};
    model(WA16, m, movf);
    run16(3, acc, ovf, to);
    checks++; if (to) begin failures++; $display("FAIL ovf_pos_timeout got=1 exp=0"); end
`ifdef MULADD_ACC_SAT_EN
    checks++; if (acc !== 16'h7FFF) begin failures++; $display("FAIL ovf_pos_acc got=%0h exp=7fff", acc); end
`else
    checks++; if (acc !== 16'hBD03) begin failures++; $display("FAIL ovf_pos_acc got=%0h exp=bd03", acc); end
`endif
    checks++; if (acc !== m[WA16-1:0]) begin failures++; $display("FAIL ovf_pos_model got=%0h exp=%0h", acc, m[WA16-1:0]); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_pos_flag got=%b exp=1", ovf); end
    qa = {-128, -128, -128}; qb = {127, 127, 127};
    model(WA16, m, movf);
    run16(3, acc, ovf, to);
    checks++; if (acc !== m[WA16-1:0]) begin failures++; $display("FAIL ovf_neg_acc got=%0h exp=%0h", acc, m[WA16-1:0]); end
    checks++; if (ovf !== movf) begin failures++; $display("FAIL ovf_neg_flag got=%b exp=%b", ovf, movf); end
    qa = {1}; qb = {1};
    run16(1, acc, ovf, to);
    checks++; if (acc !== 16'd1) begin failures++; $display("FAIL ovf_clear_acc got=%0h exp=1", acc); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear_flag got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_mid_job();
    logic [WA-1:0] acc; logic ovf; int lat; bit st, sr, to; logic ba;
    @(negedge clk);
    bus.start_i = 1'b1; bus.cfg_len_i = WC'(4);
    @(negedge clk);
    bus.start_i = 1'b0; bus.in_valid_i = 1'b1; bus.a_i = WD'(50); bus.b_i = WD'(50);
    @(negedge clk);
    bus.a_i = WD'(60); bus.b_i = WD'(60);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.acc_o !== '0) begin failures++; $display("FAIL midrst_acc got=%0h exp=0", bus.acc_o); end
    checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid_o); end
    rst = 1'b0;
    qa = {3}; qb = {3};
    drive_job(1, 0, 32'h0, 0, 0, 0, acc, ovf, lat, st, sr, ba, to);
    checks++; if (acc !== WA'(9)) begin failures++; $display("FAIL midrst_fresh_acc got=%0d exp=9", acc); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL midrst_fresh_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_illegal_start();
    logic [WA-1:0] acc; logic ovf; int lat; bit st, sr, to; logic ba;
    qa = {5, -3}; qb = {6, 2};
    drive_job(2, 0, 32'h0, 0, 3, 1, acc, ovf, lat, st, sr, ba, to);
    checks++; if (to) begin failures++; $display("FAIL illstart_timeout got=1 exp=0"); end
    checks++; if (acc !== WA'(24)) begin failures++; $display("FAIL illstart_acc got=%0d exp=24", acc); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL illstart_hold_stable got=%b exp=1", st); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL illstart_start_on_handshake got_busy=%b exp=0", ba); end
  endtask

  task automatic test_corner();
    logic [WA-1:0] acc; logic ovf; int lat; bit st, sr, to; logic ba; logic [63:0] m; bit movf;
    qa = {-128, -128, 127}; qb = {-128, 127, 127};
    model(WA, m, movf);
    drive_job(3, 0, 32'h0, 0, 0, 0, acc, ovf, lat, st, sr, ba, to);
    checks++; if (acc !== WA'(16257)) begin failures++; $display("FAIL corner_acc got=%0d exp=16257", acc); end
    checks++; if (acc !== m[WA-1:0]) begin failures++; $display("FAIL corner_model got=%0d exp=%0d", acc, m[WA-1:0]); end
  endtask

  task automatic test_random(input int jobs, input int bubble_pct, input int max_hold);
    logic [WA-1:0] acc; logic ovf; int lat, len, hold; bit st, sr, to; logic ba; logic [63:0] m; bit movf;
    for (int j = 0; j < jobs; j++) begin
      len = $urandom_range(1, 20);
      hold = $urandom_range(0, max_hold);
      qa = {}; qb = {};
      for (int k = 0; k < len; k++) begin
        qa.push_back(int'($urandom_range(0, 255)) - 128);
        qb.push_back(int'($urandom_range(0, 255)) - 128);
      end
      model(WA, m, movf);
      drive_job(len, bubble_pct, 32'h0, 0, hold, 0, acc, ovf, lat, st, sr, ba, to);
      checks++; if (to) begin failures++; $display("FAIL rand_timeout job=%0d got=1 exp=0", j); end
      checks++; if (acc !== m[WA-1:0]) begin failures++; $display("FAIL rand_acc job=%0d got=%0h exp=%0h", j, acc, m[WA-1:0]); end
      checks++; if (ovf !== movf) begin failures++; $display("FAIL rand_ovf job=%0d got=%b exp=%b", j, ovf, movf); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL rand_latency job=%0d got=%0d exp=2", j, lat); end
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL rand_hold_stable job=%0d got=%b exp=1", j, st); end
    end
  endtask

  task automatic test_back_to_back();
    test_random(3, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles_backpressure();
    test_zero_len();
    test_overflow();
    test_reset_mid_job();
    test_illegal_start();
    test_corner();
    test_random(12, 30, 3);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_acc_unit.md
# mul_acc_unit

Signed multiply-accumulate stage of the MulAdd accumulator datapath. Accepts a job length, then consumes that many operand pairs over a valid/ready stream. Multiplies each pair through one registered product stage and sums into a wide accumulator. Presents the final sum on a valid/ready output held until taken, and reports a sticky per-job overflow flag.

## Interface
- WIDTH_DATA, 8, operand width (signed two's complement)
- WIDTH_ACC, 24, accumulator/result width; must be ≥ 2*WIDTH_DATA
- WIDTH_CNT, 5, job-length counter width
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  job start; honoured only in IDLE
- cfg_len_i  input  WIDTH_CNT  beats in job, sampled with start_i
- a_i, b_i  input  WIDTH_DATA each  signed operands
- in_valid_i  input  1  operand pair valid
- in_ready_o  output  1  pair accepted when in_valid_i && in_ready_o
- acc_o  output  WIDTH_ACC  final sum, stable while out_valid_o
- ovf_o  output  1  job overflow flag, qualified by out_valid_o
- out_valid_o  output  1  result available
- out_ready_i  input  1  result consumed when out_valid_o && out_ready_i
- busy_o  output  1  high in any state other than IDLE

## Operation
- States: IDLE, ACC, FLUSH, DONE.
- IDLE: in_ready_o=0. start_i=1 clears the accumulator and ovf, loads remaining=cfg_len_i, and moves to ACC. If cfg_len_i=0, it moves directly to DONE with acc_o=0 and ovf_o=0.
- ACC: in_ready_o=1. Each accepted pair loads prod_q=a_i*b_i (signed, 2*WIDTH_DATA bits), sets prod_v, and decrements remaining. Acceptance of the pair with remaining=1 moves to FLUSH.
- Accumulate: every cycle with prod_v=1, acc <= acc + sign_ext(prod_q). prod_v clears when no pair is accepted that cycle.
- FLUSH: in_ready_o=0. Absorbs the last product, then moves to DONE.
- DONE: out_valid_o=1, and acc_o/ovf_o are held. An output handshake moves to IDLE.
- Overflow: signed overflow of the accumulator add sets ovf, which is sticky until the next start.
- start_i outside IDLE is ignored. in_valid_i outside ACC is ignored and nothing is consumed.
- Operands -128*-128 (WIDTH_DATA=8) yield +16384; no special case.

## Timing
- Reset values: in_ready_o=0, out_valid_o=0, busy_o=0, acc_o=0, ovf_o=0. State is IDLE, remaining=0, prod_v=0.
- rst asserted in any state returns everything to reset values on that edge; in-flight products are discarded.
- start_i sampled on edge E: in_ready_o=1 from E onward. busy_o=1 from E.
- Last pair accepted on edge L: the accumulator includes it at L+1. out_valid_o=1 after L+1. Latency from last acceptance to out_valid_o is 2 cycles.
- Back-to-back beats are supported at full throughput (one pair per cycle). Bubbles in in_valid_i only stretch the job.
- out_valid_o stays asserted, with acc_o/ovf_o unchanged, for any number of out_ready_i=0 cycles.
- Output handshake on edge H: IDLE after H. A new start_i is earliest honoured on edge H+1; start_i on H itself is ignored.
- The remaining counter never wraps. No beat is accepted once remaining reaches 0.

## Configuration
- MULADD_ACC_SAT_EN defined: on signed overflow the accumulator clamps to +2^(WIDTH_ACC-1)-1 or -2^(WIDTH_ACC-1), and ovf is set.
- MULADD_ACC_SAT_EN undefined: the accumulator wraps modulo 2^WIDTH_ACC, and ovf is still set.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared package muladd_pkg holds:
  - the state enum type (IDLE/ACC/FLUSH/DONE);
  - default width constants;
  - a saturation-limit helper function.
- One sub-module, mac_product_reg: the registered signed multiplier stage (prod_q, prod_v). Everything else is inline.

## Test plan
- Basic job: start with cfg_len=3, pairs (2,3),(−4,5),(7,7) back-to-back, out_ready_i=1 → out_valid_o two cycles after the 3rd acceptance, acc_o=35, ovf_o=0, busy_o falls the next cycle.
- Bubbles and backpressure: cfg_len=2, in_valid_i toggling 1-0-0-1 with pairs (10,10),(−1,1), out_ready_i=0 for 5 cycles → acc_o=99 held stable for all 5 cycles; single handshake returns to IDLE.
- Zero length: start with cfg_len=0 → out_valid_o next cycle, acc_o=0, in_ready_o never asserted.
- Overflow with WIDTH_ACC=16: cfg_len=3 of (127,127) → ovf_o=1. acc_o=32767 with MULADD_ACC_SAT_EN; acc_o=48387 mod 2^16 as signed (−17149) without it.
- Reset mid-job: rst=1 after the 2nd of 4 beats → all outputs 0 on the next cycle. A fresh job with cfg_len=1, (3,3) then gives acc_o=9 with no residue.
- Illegal start: start_i pulsed during ACC and DONE → ignored; the in-progress result is unchanged.
